// File: rtl/mesh_load_sequencer.sv
// Program-load sequencer for the 4-lane mesh front end.
// Collects conf/word0/word1 beats per lane from the host, fires one load
// strobe, then waits for every lane to report done or for the wait budget
// to run out.
module mesh_load_sequencer #(
    parameter int LANES   = 4,
    parameter int CONF_W  = 64,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       host_valid,
    output logic                       host_ready,
    input  logic [CONF_W-1:0]          host_data,
    output logic [LANES*CONF_W-1:0]    cfg_vec,
    output logic [LANES*2*DATA_W-1:0]  load_data,
    output logic                       load,
    input  logic [LANES-1:0]           lane_done,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout
);

    localparam int BEATS  = 3 * LANES;
    localparam int BC_W   = $clog2(BEATS);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    // wait_cnt only has to reach TIMEOUT-1 before the sequence leaves WAIT
    localparam int WC_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_LOAD = 3'd2,
        S_WAIT = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t                     r_state;
    logic [BC_W-1:0]            r_beat_cnt;
    logic [LANE_W-1:0]          r_lane;
    logic [1:0]                 r_slot;
    logic [WC_W-1:0]            r_wait_cnt;
    logic [LANES-1:0]           r_done_seen;
    logic                       r_host_ready;
    logic                       r_load;
    logic                       r_busy;
    logic                       r_done;
    logic [LANES*CONF_W-1:0]    r_cfg_vec;
    logic [LANES*2*DATA_W-1:0]  r_load_data;

    logic                       w_beat_fire;
    logic                       w_all_done;
    logic                       w_timeout;

    // host_ready is only ever high in FILL, so a fire is always a FILL beat
    assign w_beat_fire = r_host_ready & host_valid;
    // a lane_done arriving in the same cycle still counts toward completion
    assign w_all_done  = &(r_done_seen | lane_done);
    // completion takes precedence over the expiring wait budget
    assign w_timeout   = (r_state == S_WAIT) && !w_all_done && (r_wait_cnt == WAIT_LAST);

    assign host_ready = r_host_ready;
    assign load       = r_load;
    assign busy       = r_busy;
    assign done       = r_done;
    assign timeout    = w_timeout;
    assign cfg_vec    = r_cfg_vec;
    assign load_data  = r_load_data;

    // Sequencing FSM with registered control outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_beat_cnt   <= '0;
            r_lane       <= '0;
            r_slot       <= '0;
            r_wait_cnt   <= '0;
            r_done_seen  <= '0;
            r_host_ready <= 1'b0;
            r_load       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_FILL;
                        r_beat_cnt   <= '0;
                        r_lane       <= '0;
                        r_slot       <= '0;
                        r_host_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (w_beat_fire) begin
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_state      <= S_LOAD;
                            r_host_ready <= 1'b0;
                            r_load       <= 1'b1;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                            if (r_slot == 2'd2) begin
                                r_slot <= 2'd0;
                                r_lane <= r_lane + 1'b1;
                            end else begin
                                r_slot <= r_slot + 1'b1;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    r_done_seen <= '0;
                    r_wait_cnt  <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    r_done_seen <= r_done_seen | lane_done;
                    r_wait_cnt  <= r_wait_cnt + 1'b1;
                    if (w_all_done) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_host_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    // Beat staging: slot 0 fills the lane config, slots 1/2 the two data words
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cfg_vec   <= '0;
            r_load_data <= '0;
        end else if (w_beat_fire) begin
            for (int i = 0; i < LANES; i++) begin
                if (r_lane == LANE_W'(i)) begin
                    case (r_slot)
                        2'd0:    r_cfg_vec[i*CONF_W +: CONF_W]           <= host_data;
                        2'd1:    r_load_data[(2*i)*DATA_W +: DATA_W]     <= host_data[DATA_W-1:0];
                        2'd2:    r_load_data[(2*i+1)*DATA_W +: DATA_W]   <= host_data[DATA_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mesh_load_sequencer.sv
// Directed bench for mesh_load_sequencer: reset, nominal load, backpressure
// with staggered lane completion, timeout, completion/timeout tie, ignored
// start and reset in the middle of FILL.
module tb_mesh_load_sequencer;

    localparam int LANES   = 4;
    localparam int CONF_W  = 64;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       start;
    logic                       host_valid;
    logic                       host_ready;
    logic [CONF_W-1:0]          host_data;
    logic [LANES*CONF_W-1:0]    cfg_vec;
    logic [LANES*2*DATA_W-1:0]  load_data;
    logic                       load;
    logic [LANES-1:0]           lane_done;
    logic                       busy;
    logic                       done;
    logic                       timeout;

    int n_checks = 0;
    int n_errors = 0;

    logic [LANES*CONF_W-1:0]    exp_cfg;
    logic [LANES*2*DATA_W-1:0]  exp_ld;

    always #5 clk = ~clk;

    mesh_load_sequencer #(
        .LANES   (LANES),
        .CONF_W  (CONF_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_data  (host_data),
        .cfg_vec    (cfg_vec),
        .load_data  (load_data),
        .load       (load),
        .lane_done  (lane_done),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout)
    );

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one clock and settle past the edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // lane n/3 beat: conf carries the tag and lane number; data words carry
    // junk in the upper half that the sequencer must discard
    function automatic logic [63:0] beat_val(input int n, input logic [15:0] t);
        int lane;
        int slot;
        logic [31:0] lo;
        lane = n / 3;
        slot = n % 3;
        if (slot == 0) return {t, 44'h0, 4'(lane)};
        lo = {t ^ 16'hC0DE, 16'h0000};
        lo = lo + 32'(((slot == 1) ? 32'hA0 : 32'hB0) + lane);
        return {32'hFFFF_FFFF, lo};
    endfunction

    // feed nbeats beats, optionally with host_valid low every other cycle
    task automatic fill(input logic [15:0] t, input bit toggle, input int nbeats);
        int n;
        int c;
        int lane;
        int slot;
        logic [63:0] b;
        n = 0;
        c = 0;
        while (n < nbeats && c < 200) begin
            host_valid = !(toggle && (c % 2 == 1));
            b = beat_val(n, t);
            host_data = b;
            step();
            if (host_valid) begin
                lane = n / 3;
                slot = n % 3;
                if (slot == 0) exp_cfg[lane*CONF_W +: CONF_W] = b;
                else           exp_ld[(2*lane + slot - 1)*DATA_W +: DATA_W] = b[DATA_W-1:0];
                n++;
            end
            c++;
        end
        host_valid = 1'b0;
        host_data  = '0;
    endtask

    task automatic check_loaded(input string tag);
        check_val({tag, "_load"},     256'(load),       256'(1));
        check_val({tag, "_ready"},    256'(host_ready), 256'(0));
        check_val({tag, "_busy"},     256'(busy),       256'(1));
        check_val({tag, "_cfg_vec"},  256'(cfg_vec),    256'(exp_cfg));
        check_val({tag, "_load_data"},256'(load_data),  256'(exp_ld));
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        host_valid = 1'b0;
        host_data  = '0;
        lane_done  = '0;
        exp_cfg    = '0;
        exp_ld     = '0;

        // reset held three cycles
        repeat (3) step();
        check_val("rst_ready",     256'(host_ready), 256'(0));
        check_val("rst_busy",      256'(busy),       256'(0));
        check_val("rst_load",      256'(load),       256'(0));
        check_val("rst_done",      256'(done),       256'(0));
        check_val("rst_timeout",   256'(timeout),    256'(0));
        check_val("rst_cfg_vec",   256'(cfg_vec),    256'(0));
        check_val("rst_load_data", 256'(load_data),  256'(0));
        reset = 1'b1;
        step();
        check_val("idle_busy", 256'(busy), 256'(0));

        // nominal load
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("nom_fill_ready", 256'(host_ready), 256'(1));
        check_val("nom_fill_busy",  256'(busy),       256'(1));
        fill(16'hC0DE, 1'b0, 12);
        check_val("nom_lane2_word1", 256'(load_data[5*DATA_W +: DATA_W]), 256'(32'h0000_00B2));
        check_loaded("nom");
        step();
        check_val("nom_load_once", 256'(load), 256'(0));
        check_val("nom_t1_done",   256'(done), 256'(0));
        step();
        lane_done = 4'b1111;
        #1;
        check_val("nom_t2_timeout", 256'(timeout), 256'(0));
        step();
        lane_done = 4'b0000;
        check_val("nom_done",     256'(done), 256'(1));
        check_val("nom_fin_busy", 256'(busy), 256'(1));
        step();
        check_val("nom_done_pulse", 256'(done), 256'(0));
        check_val("nom_idle_busy",  256'(busy), 256'(0));
        check_val("nom_hold_cfg",   256'(cfg_vec), 256'(exp_cfg));

        // backpressure plus staggered lane completion 0,2,1,3
        start = 1'b1;
        step();
        start = 1'b0;
        fill(16'h5A5A, 1'b1, 12);
        check_loaded("stg");
        step();
        lane_done = 4'b0001;
        step();
        lane_done = 4'b0100;
        check_val("stg_done_t2", 256'(done), 256'(0));
        step();
        lane_done = 4'b0010;
        check_val("stg_done_t3", 256'(done), 256'(0));
        step();
        lane_done = 4'b1000;
        check_val("stg_done_t4", 256'(done), 256'(0));
        step();
        lane_done = 4'b0000;
        check_val("stg_done", 256'(done), 256'(1));
        step();
        check_val("stg_idle_busy", 256'(busy), 256'(0));

        // timeout with lane 3 stalled
        start = 1'b1;
        step();
        start = 1'b0;
        fill(16'h7777, 1'b0, 12);
        check_val("to_load", 256'(load), 256'(1));
        lane_done = 4'b0111;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_val($sformatf("to_pulse_t%0d", k), 256'(timeout), 256'(k == 8));
            check_val($sformatf("to_done_t%0d", k),  256'(done),    256'(0));
        end
        step();
        check_val("to_after_timeout", 256'(timeout),    256'(0));
        check_val("to_after_done",    256'(done),       256'(0));
        check_val("to_idle_busy",     256'(busy),       256'(0));
        check_val("to_idle_ready",    256'(host_ready), 256'(0));
        check_val("to_hold_ld",       256'(load_data),  256'(exp_ld));
        lane_done = 4'b0000;
        step();
        check_val("to_no_late_done", 256'(done), 256'(0));

        // completion on the final wait cycle beats the timeout
        start = 1'b1;
        step();
        start = 1'b0;
        fill(16'h3333, 1'b0, 12);
        lane_done = 4'b0111;
        repeat (8) step();
        lane_done = 4'b1111;
        #1;
        check_val("tie_no_timeout", 256'(timeout), 256'(0));
        step();
        lane_done = 4'b0000;
        check_val("tie_done", 256'(done), 256'(1));
        step();

        // start held high: one sequence, next begins only from IDLE
        start = 1'b1;
        step();
        fill(16'h4444, 1'b0, 12);
        check_loaded("ign");
        step();
        lane_done = 4'b1111;
        step();
        lane_done = 4'b0000;
        check_val("ign_done", 256'(done), 256'(1));
        step();
        check_val("ign_idle_busy",  256'(busy),       256'(0));
        check_val("ign_idle_ready", 256'(host_ready), 256'(0));
        step();
        start = 1'b0;
        check_val("ign_restart_ready", 256'(host_ready), 256'(1));
        check_val("ign_restart_busy",  256'(busy),       256'(1));

        // reset after beat 5 of a fresh fill
        fill(16'h9999, 1'b0, 5);
        reset = 1'b0;
        step();
        exp_cfg = '0;
        exp_ld  = '0;
        check_val("mid_rst_cfg",   256'(cfg_vec),    256'(0));
        check_val("mid_rst_ld",    256'(load_data),  256'(0));
        check_val("mid_rst_load",  256'(load),       256'(0));
        check_val("mid_rst_busy",  256'(busy),       256'(0));
        check_val("mid_rst_ready", 256'(host_ready), 256'(0));
        reset = 1'b1;
        step();
        check_val("mid_rst_no_load", 256'(load), 256'(0));
        start = 1'b1;
        step();
        start = 1'b0;
        fill(16'h2468, 1'b0, 12);
        check_val("mid_lane0_conf", 256'(cfg_vec[CONF_W-1:0]), 256'(64'h2468_0000_0000_0000));
        check_loaded("mid");
        step();
        lane_done = 4'b1111;
        step();
        lane_done = 4'b0000;
        check_val("mid_done", 256'(done), 256'(1));
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
